// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer, mid-bit sampling with a counter,
// registered byteReady/frameError strobes. A frame with a bad stop bit is never delivered.
module uart_rx #(
  parameter int DELAY_FRAMES = 234,
  parameter int HALF_DELAY   = DELAY_FRAMES / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uartRx,
  output logic       byteReady,
  output logic [7:0] dataOut,
  output logic       frameError,
  output logic       busy
);

  localparam int CNT_W = $clog2(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_e;

  logic             sync_q;
  logic             rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             byte_ready_q, byte_ready_d;
  logic             frame_error_q, frame_error_d;
  logic             busy_q, busy_d;

  // Two-stage synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= uartRx;
      rx_s_q <= sync_q;
    end
  end

  // Framing state machine: next state, counters, shift register and strobes.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_d        = data_q;
    byte_ready_d  = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end else begin
            // start bit vanished before mid-bit: treat as line noise
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d       = shift_q;
            byte_ready_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        // a held-low line (break) must not re-trigger a start until it returns high
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'h00;
      data_q        <= 8'h00;
      byte_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_q        <= data_d;
      byte_ready_q  <= byte_ready_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign byteReady  = byte_ready_q;
  assign frameError = frame_error_q;
  assign dataOut    = data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a short-divider instance for framing/timing cases
// and a DELAY_FRAMES=50 instance for +/-2% baud-skew reception.
module tb_uart_rx;

  localparam int DF  = 8;
  localparam int HD  = 4;
  localparam int DF2 = 50;
  localparam int HD2 = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx1, rx2;
  logic       br1, fe1, bz1, br2, fe2, bz2;
  logic [7:0] do1, do2;

  uart_rx #(.DELAY_FRAMES(DF), .HALF_DELAY(HD)) dut1 (
    .clk(clk), .rst(rst), .uartRx(rx1),
    .byteReady(br1), .dataOut(do1), .frameError(fe1), .busy(bz1)
  );

  uart_rx #(.DELAY_FRAMES(DF2), .HALF_DELAY(HD2)) dut2 (
    .clk(clk), .rst(rst), .uartRx(rx2),
    .byteReady(br2), .dataOut(do2), .frameError(fe2), .busy(bz2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         when;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [7:0] good1 = 8'h00;
  logic [7:0] good2 = 8'h00;
  int         n_chk = 0;
  int         n_pass = 0;
  logic       prev1 = 1'b0;
  logic       prev2 = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input int dut, input logic v);
    if (dut == 1) rx1 = v;
    else rx2 = v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transmit one 10-bit frame at p cycles/bit; stop_hi=0 forces a bad stop bit.
  // Strobe cycle: 2 sync stages + 1 IDLE detect cycle, then HALF + 9 bit periods.
  task automatic send(input int dut, input logic [7:0] b, input int p, input bit stop_hi);
    logic [9:0] bits;
    exp_t       e;
    int         hd, df;
    bits   = {stop_hi, b, 1'b0};
    hd     = (dut == 1) ? HD : HD2;
    df     = (dut == 1) ? DF : DF2;
    e.err  = !stop_hi;
    e.when = cyc + 3 + hd + 9 * df;
    if (dut == 1) begin
      if (stop_hi) good1 = b;
      e.data = good1;
      q1.push_back(e);
    end else begin
      if (stop_hi) good2 = b;
      e.data = good2;
      q2.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      drive(dut, bits[i]);
      tick(p);
    end
  endtask

  task automatic judge(input int dut, input logic br, input logic fe, input logic bz,
                       input logic [7:0] d, input logic prev);
    exp_t e;
    int   sz;
    if (br || fe) begin
      check("strobe_exclusive", int'(br && fe), 0);
      check("strobe_back_to_back", int'(prev), 0);
      sz = (dut == 1) ? q1.size() : q2.size();
      if (sz == 0) begin
        check("unexpected_strobe", dut, 0);
      end else begin
        if (dut == 1) e = q1.pop_front();
        else e = q2.pop_front();
        check("strobe_kind_is_error", int'(fe), int'(e.err));
        check("strobe_data", int'(d), int'(e.data));
        check("strobe_cycle", cyc, e.when);
        check("busy_in_strobe_cycle", int'(bz), int'(e.err));
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      judge(1, br1, fe1, bz1, do1, prev1);
      judge(2, br2, fe2, bz2, do2, prev2);
    end
    prev1 <= !rst && (br1 || fe1);
    prev2 <= !rst && (br2 || fe2);
  end

  initial begin
    int         busy_cnt;
    int         t;
    logic [7:0] b;
    bit         ok;
    int         p;

    rst = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    tick(3);
    check("reset_byteReady", int'(br1), 0);
    check("reset_frameError", int'(fe1), 0);
    check("reset_busy", int'(bz1), 0);
    check("reset_dataOut", int'(do1), 0);
    check("reset_dataOut_dut2", int'(do2), 0);
    rst = 1'b0;
    tick(5);

    // single frame at exact baud
    send(1, 8'hA5, DF, 1'b1);
    tick(10);
    check("busy_idle_after_A5", int'(bz1), 0);

    // back-to-back frames, no idle gap
    send(1, 8'h00, DF, 1'b1);
    send(1, 8'hFF, DF, 1'b1);
    send(1, 8'h81, DF, 1'b1);
    tick(10);

    // two-cycle glitch: START for HALF cycles then back to IDLE, no strobe
    rx1 = 1'b0;
    tick(2);
    rx1 = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bz1) busy_cnt++;
      tick(1);
    end
    check("glitch_busy_cycles", busy_cnt, HD);
    check("glitch_dataOut_held", int'(do1), int'(good1));
    tick(5);

    // bad stop bit, then line held low (break)
    send(1, 8'h3C, DF, 1'b0);
    tick(30);
    check("break_busy_wait_idle", int'(bz1), 1);
    check("break_dataOut_held", int'(do1), int'(good1));
    rx1 = 1'b1;
    tick(5);
    check("break_release_idle", int'(bz1), 0);
    send(1, 8'h42, DF, 1'b1);
    tick(5);

    // reset in the middle of the data bits of a partial frame
    rx1 = 1'b0;
    tick(DF);
    rx1 = 1'b1;
    tick(DF);
    rx1 = 1'b0;
    tick(DF + 3);
    rst = 1'b1;
    #1;
    check("midreset_busy", int'(bz1), 0);
    check("midreset_dataOut", int'(do1), 0);
    check("midreset_byteReady", int'(br1), 0);
    check("midreset_frameError", int'(fe1), 0);
    good1 = 8'h00;
    rx1   = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    send(1, 8'h5A, DF, 1'b1);
    tick(5);

    // randomized frames with occasional bad stop bits and random gaps
    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send(1, b, DF, ok);
      if (!ok) begin
        tick($urandom_range(0, 20));
        rx1 = 1'b1;
        tick(4);
      end else begin
        tick($urandom_range(0, 4));
      end
    end

    // +/-2% baud skew on the long-divider instance
    send(2, 8'h55, DF2 + 1, 1'b1);
    send(2, 8'hAA, DF2 + 1, 1'b1);
    tick(20);
    send(2, 8'h55, DF2 - 1, 1'b1);
    send(2, 8'hAA, DF2 - 1, 1'b1);
    tick(20);
    for (int i = 0; i < 4; i++) begin
      p = $urandom_range(DF2 - 1, DF2 + 1);
      send(2, 8'($urandom), p, 1'b1);
      tick($urandom_range(0, 10));
    end

    t = 0;
    while ((q1.size() + q2.size()) != 0 && t < 2000) begin
      tick(1);
      t++;
    end
    check("all_expected_strobes_seen", q1.size() + q2.size(), 0);
    tick(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
